universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register: the next generation of the team's 4-bit bidirectional shift register. Adds configurable width, parallel load, rotate and arithmetic-shift modes, a clock enable, serial outputs at both ends, and a frame counter that flags every WIDTH completed shifts. Used as a serial-to-parallel and parallel-to-serial converter in datapaths, on a single clock domain.

## Interface
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into the register on reset.
- CW (localparam), $clog2(WIDTH)+1, width of the shift counter.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  3  operation select (see Operation).
- sin_l  input  1  serial input entering at the MSB on a logical shift right.
- sin_r  input  1  serial input entering at the LSB on a shift left.
- pdata_in  input  WIDTH  parallel load data.
- data_out  output  WIDTH  register contents.
- sout_msb  output  1  always equal to data_out[WIDTH-1].
- sout_lsb  output  1  always equal to data_out[0].
- shift_cnt  output  CW  number of shifts since the last frame boundary, load, clear or reset.
- frame_valid  output  1  registered one-cycle pulse marking the end of a frame.

## Operation
- Priority order: reset > en == 0 > mode.
- mode encoding, applied to register q at each enabled edge:
  - 000 HOLD: q unchanged.
  - 001 SHL: q <= {q[W-2:0], sin_r}.
  - 010 SHR: q <= {sin_l, q[W-1:1]}.
  - 011 SRA: q <= {q[W-1], q[W-1:1]}; sin_l is ignored.
  - 100 ROL: q <= {q[W-2:0], q[W-1]}.
  - 101 ROR: q <= {q[0], q[W-1:1]}.
  - 110 LOAD: q <= pdata_in.
  - 111 CLR: q <= 0. CLR clears to zero, not to RESET_VAL.
- Counter rules:
  - SHL, SHR and SRA each increment shift_cnt, regardless of direction.
  - A change of direction mid-frame does not reset the count.
  - HOLD, ROL and ROR leave shift_cnt unchanged.
  - LOAD and CLR set shift_cnt to 0 and do not assert frame_valid.
- Frame boundary:
  - When a counting shift takes shift_cnt from WIDTH-1, shift_cnt wraps to 0 on that edge.
  - frame_valid is 1 for the following cycle only.
  - In that same cycle, data_out holds the WIDTH-th shifted value.
- frame_valid is 0 in every cycle except a frame boundary, including when en == 0.
- sout_msb and sout_lsb are combinational taps of q; they have no extra register stage.

## Timing
- Reset values, present one edge after reset is sampled high:
  - data_out = RESET_VAL
  - shift_cnt = 0
  - frame_valid = 0
- Reset asserted mid-frame discards the partial frame: shift_cnt = 0, no frame_valid pulse.
- All state updates on the rising clk edge. Latency from mode/data to data_out is one cycle.
- Back-to-back frames: continuous shifting gives a frame_valid pulse every WIDTH cycles, with no gap cycle.
- Deasserting en for one or more cycles stretches the frame; shift_cnt holds its value while en == 0.
- LOAD on the same edge that would have completed a frame:
  - LOAD wins: q = pdata_in, shift_cnt = 0, frame_valid stays 0.
- mode values are sampled only when en == 1 and reset == 0. No illegal encodings exist.

## Test plan
- Reset and shift: WIDTH=4, RESET_VAL=4'hA; hold reset 2 cycles, then mode=SHL, en=1, sin_r=1,0,0,0 -> data_out 0101, 1010, 0100, 1000; frame_valid=1 only in the cycle data_out=1000; shift_cnt 1, 2, 3, 0.
- Reset mid-frame: WIDTH=4, two SHR shifts with sin_l=1 from 0000 -> 1000, 1100; assert reset -> data_out=RESET_VAL, shift_cnt=0; four further SHR -> frame_valid pulses only after the 4th post-reset shift.
- Load, arithmetic shift, rotate: WIDTH=8, LOAD 8'h96, then SRA x2 -> 8'hCB, 8'hE5 (shift_cnt=2); then ROR x1 -> 8'hF2 with shift_cnt still 2, frame_valid=0 throughout.
- Enable gaps: WIDTH=4, SHL with en toggling 1,0,1,0,1,0,1 -> shift_cnt advances only on en=1 cycles; exactly one frame_valid pulse, after the 4th enabled shift; data_out constant during en=0 cycles.
- Load/clear vs boundary: WIDTH=4, three SHL shifts then LOAD 4'h5 on the 4th edge -> data_out=0101, shift_cnt=0, no frame_valid; then CLR -> data_out=0000 (not RESET_VAL), shift_cnt=0.
- Continuous and mixed-direction framing: WIDTH=8, 24 consecutive shifts alternating SHL/SHR -> frame_valid pulses after edges 8, 16 and 24; sout_msb and sout_lsb equal data_out[7] and data_out[0] in every cycle.

Source files
------------

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parametrised shift/rotate/load register with clock enable and WIDTH-shift frame counter
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata_in,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_valid
);
  logic [WIDTH-1:0] q, q_nxt;
  logic [CW-1:0] cnt_nxt;
  logic shifting, wrap;
  always_comb begin
    q_nxt = mode == 3'd1 ? {q[WIDTH-2:0], sin_r} :
            mode == 3'd2 ? {sin_l, q[WIDTH-1:1]} :
            mode == 3'd3 ? {q[WIDTH-1], q[WIDTH-1:1]} :
            mode == 3'd4 ? {q[WIDTH-2:0], q[WIDTH-1]} :
            mode == 3'd5 ? {q[0], q[WIDTH-1:1]} :
            mode == 3'd6 ? pdata_in :
            mode == 3'd7 ? '0 : q;
    shifting = mode == 3'd1 || mode == 3'd2 || mode == 3'd3;
    wrap = shifting && shift_cnt == CW'(WIDTH - 1);
    cnt_nxt = mode[2:1] == 2'b11 || wrap ? '0 :
              shifting ? shift_cnt + 1'b1 : shift_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
      shift_cnt <= '0;
      frame_valid <= 1'b0;
    end else if (en) begin
      q <= q_nxt;
      shift_cnt <= cnt_nxt;
      frame_valid <= wrap;
    end else begin
      frame_valid <= 1'b0;
    end
  end
  assign data_out = q;
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: scoreboard bench driving a 4-bit and an 8-bit instance with directed vectors
module tb_universal_shift_reg;
  typedef struct {
    int w;
    int id;
    logic [7:0] d;
    logic [3:0] c;
    logic fv;
  } exp_t;
  logic clk = 1'b0;
  logic rst4 = 1'b0, rst8 = 1'b0, en4 = 1'b0, en8 = 1'b0;
  logic [2:0] mode = 3'd0;
  logic sin_l = 1'b0, sin_r = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [3:0] d4;
  logic [7:0] d8;
  logic [2:0] c4;
  logic [3:0] c8;
  logic msb4, lsb4, fv4, msb8, lsb8, fv8;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, n_id = 0;
  always #5 clk = ~clk;
  universal_shift_reg #(.WIDTH(4), .RESET_VAL(4'hA)) u4 (
    .clk(clk), .reset(rst4), .en(en4), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pdata_in(pd[3:0]), .data_out(d4), .sout_msb(msb4), .sout_lsb(lsb4),
    .shift_cnt(c4), .frame_valid(fv4)
  );
  universal_shift_reg #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .en(en8), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pdata_in(pd), .data_out(d8), .sout_msb(msb8), .sout_lsb(lsb8),
    .shift_cnt(c8), .frame_valid(fv8)
  );
  task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h want %h", nm, id, got, want);
    end
  endtask
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] gd;
      logic [3:0] gc;
      logic gf, gm, gl, wm;
      e = sb.pop_front();
      gd = e.w == 4 ? {4'h0, d4} : d8;
      gc = e.w == 4 ? {1'b0, c4} : c8;
      gf = e.w == 4 ? fv4 : fv8;
      gm = e.w == 4 ? msb4 : msb8;
      gl = e.w == 4 ? lsb4 : lsb8;
      wm = e.w == 4 ? e.d[3] : e.d[7];
      chk("data_out", e.id, gd, e.d);
      chk("shift_cnt", e.id, {4'h0, gc}, {4'h0, e.c});
      chk("frame_valid", e.id, {7'h0, gf}, {7'h0, e.fv});
      chk("sout_msb", e.id, {7'h0, gm}, {7'h0, wm});
      chk("sout_lsb", e.id, {7'h0, gl}, {7'h0, e.d[0]});
    end
  end
  task automatic cyc(input int w, input logic r, input logic e, input logic [2:0] m,
                     input logic sl, input logic sr, input logic [7:0] p,
                     input logic [7:0] xd, input logic [3:0] xc, input logic xf);
    exp_t x;
    rst4 = w == 4 && r;
    rst8 = w == 8 && r;
    en4 = w == 4 && e;
    en8 = w == 8 && e;
    mode = m;
    sin_l = sl;
    sin_r = sr;
    pd = p;
    @(posedge clk);
    x.w = w; x.id = n_id++; x.d = xd; x.c = xc; x.fv = xf;
    sb.push_back(x);
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    cyc(4, 1, 0, 0, 0, 0, 0, 8'hA, 0, 0);
    cyc(4, 1, 0, 0, 0, 0, 0, 8'hA, 0, 0);
    cyc(4, 0, 1, 1, 0, 1, 0, 8'h5, 1, 0);
    cyc(4, 0, 1, 1, 0, 0, 0, 8'hA, 2, 0);
    cyc(4, 0, 1, 1, 0, 0, 0, 8'h4, 3, 0);
    cyc(4, 0, 1, 1, 0, 0, 0, 8'h8, 0, 1);
    cyc(4, 0, 1, 0, 0, 0, 0, 8'h8, 0, 0);
    cyc(4, 0, 1, 7, 0, 0, 0, 8'h0, 0, 0);
    cyc(4, 0, 1, 2, 1, 0, 0, 8'h8, 1, 0);
    cyc(4, 0, 1, 2, 1, 0, 0, 8'hC, 2, 0);
    cyc(4, 1, 1, 2, 1, 0, 0, 8'hA, 0, 0);
    cyc(4, 0, 1, 2, 0, 0, 0, 8'h5, 1, 0);
    cyc(4, 0, 1, 2, 0, 0, 0, 8'h2, 2, 0);
    cyc(4, 0, 1, 2, 0, 0, 0, 8'h1, 3, 0);
    cyc(4, 0, 1, 2, 0, 0, 0, 8'h0, 0, 1);
    cyc(4, 0, 1, 0, 0, 0, 0, 8'h0, 0, 0);
    cyc(8, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    cyc(8, 0, 1, 6, 0, 0, 8'h96, 8'h96, 0, 0);
    cyc(8, 0, 1, 3, 0, 0, 0, 8'hCB, 1, 0);
    cyc(8, 0, 1, 3, 1, 0, 0, 8'hE5, 2, 0);
    cyc(8, 0, 1, 5, 0, 0, 0, 8'hF2, 2, 0);
    cyc(8, 0, 1, 4, 0, 0, 0, 8'hE5, 2, 0);
    cyc(4, 1, 0, 0, 0, 0, 0, 8'hA, 0, 0);
    cyc(4, 0, 1, 1, 0, 1, 0, 8'h5, 1, 0);
    cyc(4, 0, 0, 1, 0, 1, 0, 8'h5, 1, 0);
    cyc(4, 0, 1, 1, 0, 1, 0, 8'hB, 2, 0);
    cyc(4, 0, 0, 1, 0, 1, 0, 8'hB, 2, 0);
    cyc(4, 0, 1, 1, 0, 1, 0, 8'h7, 3, 0);
    cyc(4, 0, 0, 1, 0, 1, 0, 8'h7, 3, 0);
    cyc(4, 0, 1, 1, 0, 1, 0, 8'hF, 0, 1);
    cyc(4, 0, 0, 1, 0, 1, 0, 8'hF, 0, 0);
    cyc(4, 1, 0, 0, 0, 0, 0, 8'hA, 0, 0);
    cyc(4, 0, 1, 1, 0, 0, 0, 8'h4, 1, 0);
    cyc(4, 0, 1, 1, 0, 0, 0, 8'h8, 2, 0);
    cyc(4, 0, 1, 1, 0, 0, 0, 8'h0, 3, 0);
    cyc(4, 0, 1, 6, 0, 0, 8'h5, 8'h5, 0, 0);
    cyc(4, 0, 1, 0, 0, 0, 0, 8'h5, 0, 0);
    cyc(4, 0, 1, 7, 0, 0, 0, 8'h0, 0, 0);
    cyc(8, 0, 1, 7, 0, 0, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 24; k++)
      cyc(8, 0, 1, k % 2 ? 3'd1 : 3'd2, 1, 1, 0, k % 2 ? 8'h01 : 8'h80, 4'(k % 8), k % 8 == 0);
    cyc(8, 0, 0, 1, 0, 0, 0, 8'h80, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", n_id, 8'(sb.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
